// File: rtl/rv_mem_pkg.sv
// ============================================================================
// Module   : rv_mem_pkg
// Brief    : Shared FUNCT3 load/store encodings and MEM-stage FSM state type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/load_store_align.sv
// ============================================================================
// Module   : load_store_align
// Brief    : Byte-lane steering for stores and extract/extend for loads.
//            Misalignment detection is present only with MISALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [7:0]  w_sel_byte;
  logic [15:0] w_sel_half;

  assign w_sel_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_sel_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_byte_en   = 4'hF;
    o_wword     = i_wdata;
    o_rdata_ext = i_rdata;
    unique case (i_funct3)
      F3_B, F3_BU: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_wword     = {4{i_wdata[7:0]}};
        o_rdata_ext = (i_funct3 == F3_BU) ? {24'h0, w_sel_byte}
                                          : {{24{w_sel_byte[7]}}, w_sel_byte};
      end
      F3_H, F3_HU: begin
        o_byte_en   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword     = {2{i_wdata[15:0]}};
        o_rdata_ext = (i_funct3 == F3_HU) ? {16'h0, w_sel_half}
                                          : {{16{w_sel_half[15]}}, w_sel_half};
      end
      // F3_W and every unlisted code fall through as a full-word access
      default: begin
        o_byte_en   = 4'hF;
        o_wword     = i_wdata;
        o_rdata_ext = i_rdata;
      end
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  logic w_is_byte;
  logic w_is_half;

  assign w_is_byte  = (i_funct3 == F3_B) || (i_funct3 == F3_BU);
  assign w_is_half  = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
  assign o_misalign = (w_is_half & i_addr_lo[0]) |
                      (~w_is_byte & ~w_is_half & (i_addr_lo != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : MEM-stage data memory responder with fixed-latency BUSYWAIT
//            handshake. Optional misalignment trap via MISALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MEM_READ_EN,
  input  logic        MEM_WRITE_EN,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRITE_DATA,
  output logic        MEM_BUSYWAIT,
  output logic [31:0] MEM_READ_DATA,
  output logic        MEM_MISALIGN
);

  localparam int c_AW    = $clog2(DEPTH_WORDS);
  localparam int c_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  mem_state_t         r_state;
  mem_state_t         w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_rdata;
  logic               r_misalign;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_req;
  logic               w_commit;
  logic               w_mem_we;
  logic [c_AW-1:0]    w_idx;
  logic [31:0]        w_rword;
  logic [3:0]         w_byte_en;
  logic [31:0]        w_wword;
  logic [31:0]        w_rdata_ext;
  logic               w_mis;
  logic [31-c_AW-2:0] w_unused_addr;

  assign w_req         = MEM_READ_EN | MEM_WRITE_EN;
  assign w_idx         = ADDR[c_AW+1:2];
  assign w_unused_addr = ADDR[31:c_AW+2];
  assign w_rword       = r_mem[w_idx];

  load_store_align u_align (
    .i_funct3    (FUNCT3),
    .i_addr_lo   (ADDR[1:0]),
    .i_wdata     (WRITE_DATA),
    .i_rdata     (w_rword),
    .o_byte_en   (w_byte_en),
    .o_wword     (w_wword),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_mis)
  );

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_next   = ST_DONE;
            w_commit = 1'b1;
          end else begin
            w_next   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next   = ST_DONE;
          w_commit = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign MEM_BUSYWAIT = w_req & (r_state != ST_DONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rdata    <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_misalign <= w_commit & w_mis;
      if ((r_state == ST_IDLE) && w_req) begin
        r_cnt <= c_CNT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      // Dual-enable is a store that zeroes the load result; a pure store leaves it alone
      if (w_commit) begin
        if (MEM_WRITE_EN) begin
          if (MEM_READ_EN) begin
            r_rdata <= 32'h0;
          end
        end else if (w_mis) begin
          r_rdata <= 32'h0;
        end else begin
          r_rdata <= w_rdata_ext;
        end
      end
    end
  end

  // RESET_N gate keeps a held request from committing while reset is asserted
  assign w_mem_we = w_commit & MEM_WRITE_EN & ~w_mis & RESET_N;

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  assign MEM_READ_DATA = r_rdata;
  assign MEM_MISALIGN  = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed bench for data_mem_ctrl (LATENCY=3 and LATENCY=1 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

`ifdef MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        re0 = 1'b0, we0 = 1'b0, re1 = 1'b0, we1 = 1'b0;
  logic [2:0]  f3_0 = 3'b0, f3_1 = 3'b0;
  logic [31:0] a0 = 32'h0, a1 = 32'h0, wd0 = 32'h0, wd1 = 32'h0;
  logic        busy0, busy1, mis0, mis1;
  logic [31:0] rdata0, rdata1;

  int          checks = 0;
  int          errors = 0;
  int          nb;
  logic [31:0] rd;
  logic        mis;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .MEM_READ_EN(re0), .MEM_WRITE_EN(we0),
    .FUNCT3(f3_0), .ADDR(a0), .WRITE_DATA(wd0),
    .MEM_BUSYWAIT(busy0), .MEM_READ_DATA(rdata0), .MEM_MISALIGN(mis0)
  );

  data_mem_ctrl #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RESET_N(rst_n), .MEM_READ_EN(re1), .MEM_WRITE_EN(we1),
    .FUNCT3(f3_1), .ADDR(a1), .WRITE_DATA(wd1),
    .MEM_BUSYWAIT(busy1), .MEM_READ_DATA(rdata1), .MEM_MISALIGN(mis1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with requests dropped
  task automatic access(input bit lat1, input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int n, output logic [31:0] r, output logic m);
    if (lat1) begin re1 = re; we1 = we; f3_1 = f3; a1 = a; wd1 = wd; end
    else      begin re0 = re; we0 = we; f3_0 = f3; a0 = a; wd0 = wd; end
    #1;
    n = 0;
    while ((lat1 ? busy1 : busy0) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    r = lat1 ? rdata1 : rdata0;
    m = lat1 ? mis1 : mis0;
    @(negedge clk);
    re0 = 1'b0; we0 = 1'b0; re1 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_mis", {31'h0, mis0}, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, nb, rd, mis);
    chk("sw_busy_cycles", nb, 3);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, nb, rd, mis);
    chk("lw_busy_cycles", nb, 3);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_mis", {31'h0, mis}, 32'h0);

    access(0, 0, 1, 3'b010, 32'h20, 32'h0, nb, rd, mis);
    access(0, 0, 1, 3'b000, 32'h21, 32'h12345680, nb, rd, mis);
    chk("sb_keeps_rdata", rd, 32'hDEADBEEF);
    access(0, 1, 0, 3'b000, 32'h21, 32'h0, nb, rd, mis);
    chk("lb_sext", rd, 32'hFFFFFF80);
    access(0, 1, 0, 3'b100, 32'h21, 32'h0, nb, rd, mis);
    chk("lbu_zext", rd, 32'h00000080);
    access(0, 1, 0, 3'b010, 32'h20, 32'h0, nb, rd, mis);
    chk("sb_lane_only", rd, 32'h00008000);

    access(0, 0, 1, 3'b010, 32'h30, 32'h0, nb, rd, mis);
    access(0, 0, 1, 3'b001, 32'h32, 32'h5555ABCD, nb, rd, mis);
    access(0, 1, 0, 3'b010, 32'h30, 32'h0, nb, rd, mis);
    chk("sh_upper_lw", rd, 32'hABCD0000);
    access(0, 1, 0, 3'b001, 32'h32, 32'h0, nb, rd, mis);
    chk("lh_sext", rd, 32'hFFFFABCD);
    access(0, 1, 0, 3'b101, 32'h32, 32'h0, nb, rd, mis);
    chk("lhu_zext", rd, 32'h0000ABCD);
    access(0, 1, 0, 3'b111, 32'h30, 32'h0, nb, rd, mis);
    chk("unlisted_f3_word", rd, 32'hABCD0000);
    access(0, 1, 0, 3'b010, 32'h410, 32'h0, nb, rd, mis);
    chk("addr_wrap", rd, 32'hDEADBEEF);

    access(0, 1, 1, 3'b010, 32'h50, 32'hCAFEF00D, nb, rd, mis);
    chk("dual_en_rdata0", rd, 32'h0);
    access(0, 1, 0, 3'b010, 32'h50, 32'h0, nb, rd, mis);
    chk("dual_en_stored", rd, 32'hCAFEF00D);
    access(0, 0, 1, 3'b010, 32'h50, 32'h0BADF00D, nb, rd, mis);
    chk("load_then_store_old", rd, 32'hCAFEF00D);
    access(0, 1, 0, 3'b010, 32'h50, 32'h0, nb, rd, mis);
    chk("store_after_load", rd, 32'h0BADF00D);

    access(0, 0, 1, 3'b010, 32'h04, 32'h01020304, nb, rd, mis);
    access(0, 1, 0, 3'b010, 32'h05, 32'h0, nb, rd, mis);
    chk("mis_lw_cycles", nb, 3);
    chk("mis_lw_flag", {31'h0, mis}, {31'h0, MIS});
    chk("mis_lw_data", rd, MIS ? 32'h0 : 32'h01020304);
    #1;
    chk("mis_flag_clears", {31'h0, mis0}, 32'h0);
    access(0, 1, 0, 3'b001, 32'h33, 32'h0, nb, rd, mis);
    chk("mis_lh_flag", {31'h0, mis}, {31'h0, MIS});
    chk("mis_lh_data", rd, MIS ? 32'h0 : 32'hFFFFABCD);
    access(0, 1, 0, 3'b000, 32'h05, 32'h0, nb, rd, mis);
    chk("lb_odd_aligned", rd, 32'h00000003);
    chk("lb_odd_noflag", {31'h0, mis}, 32'h0);
    access(0, 0, 1, 3'b010, 32'h11, 32'hFFFFFFFF, nb, rd, mis);
    chk("mis_sw_flag", {31'h0, mis}, {31'h0, MIS});
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, nb, rd, mis);
    chk("mis_sw_mem", rd, MIS ? 32'hDEADBEEF : 32'hFFFFFFFF);

    access(0, 0, 1, 3'b010, 32'h40, 32'h11111111, nb, rd, mis);
    access(0, 1, 0, 3'b010, 32'h40, 32'h0, nb, rd, mis);
    chk("pre_abort_lw", rd, 32'h11111111);
    we0 = 1'b1; f3_0 = 3'b010; a0 = 32'h40; wd0 = 32'h22222222;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rdata0", rdata0, 32'h0);
    @(negedge clk);
    we0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 1, 0, 3'b010, 32'h40, 32'h0, nb, rd, mis);
    chk("abort_mem_kept", rd, 32'h11111111);
    chk("abort_then_lw_cycles", nb, 3);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("lat1_idle_busy", {31'h0, busy1}, 32'h0);
    end
    @(negedge clk);
    access(1, 0, 1, 3'b010, 32'h8, 32'h13579BDF, nb, rd, mis);
    chk("lat1_sw_cycles", nb, 1);
    access(1, 1, 0, 3'b010, 32'h8, 32'h0, nb, rd, mis);
    chk("lat1_lw_cycles", nb, 1);
    chk("lat1_lw_data", rd, 32'h13579BDF);
    access(1, 1, 0, 3'b100, 32'h8, 32'h0, nb, rd, mis);
    chk("lat1_lbu_cycles", nb, 1);
    chk("lat1_lbu_data", rd, 32'h000000DF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
